// File: rtl/morse_defs.sv
// Shared definitions for the Morse transmit path: FSM encoding, LUT word
// layout, segment lengths in Morse units, and the ASCII-to-Morse table.
package morse_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_LOAD,
        ST_MARK,
        ST_SPACE,
        ST_GAP
    } state_t;

    // LUT word layout: [7:5] symbol count, [4:0] symbols, first symbol at bit 4
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 5;
    localparam int SYM_MSB = 4;

    // Segment lengths in Morse time units
    localparam logic [2:0] DOT_UNITS        = 3'd1;
    localparam logic [2:0] DASH_UNITS       = 3'd3;
    localparam logic [2:0] SYM_GAP_UNITS    = 3'd1;
    localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
    localparam logic [2:0] WORD_GAP_UNITS   = 3'd7;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Mark length for one symbol bit (1 = dash, 0 = dot)
    function automatic logic [2:0] mark_units(input logic is_dash);
        return is_dash ? DASH_UNITS : DOT_UNITS;
    endfunction

    // Table contents: letters (either case) and digits; everything else len=0
    function automatic logic [7:0] lut_word(input logic [7:0] ch);
        logic [7:0] up;
        logic [7:0] w;
        up = (ch >= 8'h61 && ch <= 8'h7A) ? (ch - 8'h20) : ch;
        w  = 8'h00;
        case (up)
            8'h41: w = {3'd2, 5'b01000}; // A .-
            8'h42: w = {3'd4, 5'b10000}; // B -...
            8'h43: w = {3'd4, 5'b10100}; // C -.-.
            8'h44: w = {3'd3, 5'b10000}; // D -..
            8'h45: w = {3'd1, 5'b00000}; // E .
            8'h46: w = {3'd4, 5'b00100}; // F ..-.
            8'h47: w = {3'd3, 5'b11000}; // G --.
            8'h48: w = {3'd4, 5'b00000}; // H ....
            8'h49: w = {3'd2, 5'b00000}; // I ..
            8'h4A: w = {3'd4, 5'b01110}; // J .---
            8'h4B: w = {3'd3, 5'b10100}; // K -.-
            8'h4C: w = {3'd4, 5'b01000}; // L .-..
            8'h4D: w = {3'd2, 5'b11000}; // M --
            8'h4E: w = {3'd2, 5'b10000}; // N -.
            8'h4F: w = {3'd3, 5'b11100}; // O ---
            8'h50: w = {3'd4, 5'b01100}; // P .--.
            8'h51: w = {3'd4, 5'b11010}; // Q --.-
            8'h52: w = {3'd3, 5'b01000}; // R .-.
            8'h53: w = {3'd3, 5'b00000}; // S ...
            8'h54: w = {3'd1, 5'b10000}; // T -
            8'h55: w = {3'd3, 5'b00100}; // U ..-
            8'h56: w = {3'd4, 5'b00010}; // V ...-
            8'h57: w = {3'd3, 5'b01100}; // W .--
            8'h58: w = {3'd4, 5'b10010}; // X -..-
            8'h59: w = {3'd4, 5'b10110}; // Y -.--
            8'h5A: w = {3'd4, 5'b11000}; // Z --..
            8'h30: w = {3'd5, 5'b11111}; // 0 -----
            8'h31: w = {3'd5, 5'b01111}; // 1 .----
            8'h32: w = {3'd5, 5'b00111}; // 2 ..---
            8'h33: w = {3'd5, 5'b00011}; // 3 ...--
            8'h34: w = {3'd5, 5'b00001}; // 4 ....-
            8'h35: w = {3'd5, 5'b00000}; // 5 .....
            8'h36: w = {3'd5, 5'b10000}; // 6 -....
            8'h37: w = {3'd5, 5'b11000}; // 7 --...
            8'h38: w = {3'd5, 5'b11100}; // 8 ---..
            8'h39: w = {3'd5, 5'b11110}; // 9 ----.
            default: w = 8'h00;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ascii2morse_rom.sv
// 256 x 8 ASCII-to-Morse lookup ROM with a registered output (1-cycle
// latency). Contents come from the shared table so the ROM is a pure
// constant lookup that synthesis maps to block ROM or LUTs.
module ascii2morse_rom
    import morse_defs::*;
(
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] data
);

    // Registered read: data for addr is valid one edge after addr is stable
    // NOTE: ROM contents/output carry no reset; a reset here would stop the tools from mapping to block ROM and nothing downstream reads data before a lookup.
    always_ff @(posedge clk) begin
        data <= lut_word(addr);
    end

endmodule

// File: rtl/morse_tx.sv
// ASCII-to-Morse transmitter. Accepts one char per valid/ready handshake,
// looks it up in the ROM, then keys morse_out with dot/dash/gap timing
// derived from a prescaler (cycles per unit) and a unit down-counter.
module morse_tx
    import morse_defs::*;
#(
    parameter int UNIT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    output logic       morse_out,
    output logic       busy,
    output logic       done_tick,
    output logic       err_tick
);

    localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(UNIT_CYCLES - 1);

    state_t        state;
    state_t        state_next;
    logic [7:0]    addr;
    logic [7:0]    rom_data;
    logic [PW-1:0] prescaler;
    logic [2:0]    unit_cnt;
    logic [3:0]    sym_reg;     // symbols still to send after the current mark
    logic [2:0]    sym_left;    // symbols remaining, including the current mark

    logic          unit_done;
    logic          seg_start;
    logic [2:0]    seg_units;
    logic          sym_load;
    logic          sym_shift;
    logic          done_pulse;
    logic          err_pulse;
    logic [2:0]    rom_len;

    assign rom_len   = rom_data[LEN_MSB:LEN_LSB];
    assign unit_done = (prescaler == PRE_LAST) && (unit_cnt == 3'd1);
    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    ascii2morse_rom u_rom (
        .clk  (clk),
        .addr (addr),
        .data (rom_data)
    );

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state and per-cycle control decode
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        seg_start  = 1'b0;
        seg_units  = 3'd0;
        sym_load   = 1'b0;
        sym_shift  = 1'b0;
        done_pulse = 1'b0;
        err_pulse  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (addr == ASCII_SPACE) begin
                    state_next = ST_GAP;
                    seg_start  = 1'b1;
                    seg_units  = WORD_GAP_UNITS;
                end else if (rom_len == 3'd0) begin
                    state_next = ST_IDLE;
                    err_pulse  = 1'b1;
                end else begin
                    state_next = ST_MARK;
                    seg_start  = 1'b1;
                    seg_units  = mark_units(rom_data[SYM_MSB]);
                    sym_load   = 1'b1;
                end
            end
            ST_MARK: begin
                if (unit_done) begin
                    seg_start = 1'b1;
                    if (sym_left > 3'd1) begin
                        state_next = ST_SPACE;
                        seg_units  = SYM_GAP_UNITS;
                    end else begin
                        state_next = ST_GAP;
                        seg_units  = LETTER_GAP_UNITS;
                    end
                end
            end
            ST_SPACE: begin
                if (unit_done) begin
                    state_next = ST_MARK;
                    seg_start  = 1'b1;
                    seg_units  = mark_units(sym_reg[3]);
                    sym_shift  = 1'b1;
                end
            end
            ST_GAP: begin
                if (unit_done) begin
                    state_next = ST_IDLE;
                    done_pulse = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture the accepted char as the ROM address; ignored while busy
    always_ff @(posedge clk) begin
        if (!reset_n)                         addr <= 8'h00;
        else if (state == ST_IDLE && in_valid) addr <= in_char;
    end

    // Unit timer: both counters restart on every segment change
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescaler <= '0;
            unit_cnt  <= 3'd0;
        end else if (seg_start) begin
            prescaler <= '0;
            unit_cnt  <= seg_units;
        end else if (state == ST_MARK || state == ST_SPACE || state == ST_GAP) begin
            if (prescaler == PRE_LAST) begin
                prescaler <= '0;
                unit_cnt  <= unit_cnt - 3'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end else begin
            prescaler <= '0;
            unit_cnt  <= 3'd0;
        end
    end

    // Symbol shift register and remaining-symbol count
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sym_reg  <= 4'd0;
            sym_left <= 3'd0;
        end else if (sym_load) begin
            sym_reg  <= rom_data[SYM_MSB-1:0];
            sym_left <= rom_len;
        end else if (sym_shift) begin
            sym_reg  <= {sym_reg[2:0], 1'b0};
            sym_left <= sym_left - 3'd1;
        end
    end

    // Registered outputs: key follows the next state, ticks are single pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            morse_out <= 1'b0;
            done_tick <= 1'b0;
            err_tick  <= 1'b0;
        end else begin
            morse_out <= (state_next == ST_MARK);
            done_tick <= done_pulse;
            err_tick  <= err_pulse;
        end
    end

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx with UNIT_CYCLES=4 (dot = 4 cycles, dash = 12).
module tb_morse_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       morse_out;
    logic       busy;
    logic       done_tick;
    logic       err_tick;

    int errors = 0;
    int checks = 0;

    morse_tx #(.UNIT_CYCLES(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .morse_out (morse_out),
        .busy      (busy),
        .done_tick (done_tick),
        .err_tick  (err_tick)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle; all driving and sampling happens here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count consecutive samples with morse_out == lvl (bounded)
    task automatic count_level(input logic lvl, output int n);
        n = 0;
        while (morse_out === lvl && n < 100) begin
            n++;
            tick();
        end
    endtask

    // Count samples until done_tick, noting any key-on or err_tick seen
    task automatic count_to_done(output int n, output int ones, output int errs);
        n = 0; ones = 0; errs = 0;
        while (done_tick !== 1'b1 && n < 100) begin
            if (morse_out === 1'b1) ones++;
            if (err_tick === 1'b1) errs++;
            n++;
            tick();
        end
    endtask

    // Present a char while idle; returns just after the accept edge
    task automatic accept(input logic [7:0] ch, input logic hold);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_char  = ch;
        while (in_ready !== 1'b1 && guard < 100) begin
            guard++;
            tick();
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL accept_wait: in_ready stayed %b for %0d cycles, need 1", in_ready, guard);
        end
        tick();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_char = 8'h00;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        checks++; if (morse_out !== 1'b0) begin errors++; $display("FAIL reset_morse: got %b want 0", morse_out); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        checks++; if (done_tick !== 1'b0 || err_tick !== 1'b0) begin
            errors++; $display("FAIL reset_ticks: got done=%b err=%b want 0/0", done_tick, err_tick);
        end
    endtask

    // Single dot: high 4, low 12, then done_tick for exactly one cycle
    task automatic test_dot(input logic [7:0] ch);
        int n, ones, errs;
        accept(ch, 1'b0);
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL dot_busy: got ready=%b busy=%b want 0/1", in_ready, busy);
        end
        tick();
        checks++; if (morse_out !== 1'b0) begin errors++; $display("FAIL dot_lookup_low: got %b want 0", morse_out); end
        tick();
        checks++; if (morse_out !== 1'b1) begin errors++; $display("FAIL dot_first_high: got %b want 1 two edges after accept", morse_out); end
        count_level(1'b1, n);
        checks++; if (n != 4) begin errors++; $display("FAIL dot_high_len ch=%h: got %0d want 4", ch, n); end
        count_to_done(n, ones, errs);
        checks++; if (n != 12 || ones != 0) begin
            errors++; $display("FAIL dot_gap_len ch=%h: got %0d (highs %0d) want 12 (0)", ch, n, ones);
        end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL dot_done_ready: got ready=%b busy=%b want 1/0", in_ready, busy);
        end
        tick();
        checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL dot_done_width: got %b want 0", done_tick); end
    endtask

    // 'A' then 'T' with in_valid held; in_char changes while busy must be ignored
    task automatic test_back_to_back();
        int n, ones, errs;
        accept(8'h41, 1'b1);
        in_char = 8'h54;
        tick(); tick();
        checks++; if (morse_out !== 1'b1) begin errors++; $display("FAIL a_first_high: got %b want 1", morse_out); end
        count_level(1'b1, n);
        checks++; if (n != 4)  begin errors++; $display("FAIL a_dot_len: got %0d want 4", n); end
        count_level(1'b0, n);
        checks++; if (n != 4)  begin errors++; $display("FAIL a_sym_gap: got %0d want 4", n); end
        count_level(1'b1, n);
        checks++; if (n != 12) begin errors++; $display("FAIL a_dash_len: got %0d want 12", n); end
        count_to_done(n, ones, errs);
        checks++; if (n != 12) begin errors++; $display("FAIL a_letter_gap: got %0d want 12", n); end
        tick();
        checks++; if (busy !== 1'b1 || done_tick !== 1'b0) begin
            errors++; $display("FAIL t_accept_next: got busy=%b done=%b want 1/0", busy, done_tick);
        end
        in_valid = 1'b0;
        tick();
        checks++; if (morse_out !== 1'b0) begin errors++; $display("FAIL t_lookup_low: got %b want 0", morse_out); end
        tick();
        count_level(1'b1, n);
        checks++; if (n != 12) begin errors++; $display("FAIL t_dash_len: got %0d want 12", n); end
        count_to_done(n, ones, errs);
        checks++; if (n != 12) begin errors++; $display("FAIL t_letter_gap: got %0d want 12", n); end
        tick();
    endtask

    // '0': five dashes, 4-cycle gaps between, 12-cycle final gap, one done_tick
    task automatic test_zero();
        int n, ones, errs, bad;
        bad = 0;
        accept(8'h30, 1'b0);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            count_level(1'b1, n);
            if (n != 12) bad++;
            if (i < 4) begin
                count_level(1'b0, n);
                if (n != 4) bad++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL zero_segments: got %0d wrong segment lengths want 0", bad); end
        count_to_done(n, ones, errs);
        checks++; if (n != 12) begin errors++; $display("FAIL zero_final_gap: got %0d want 12", n); end
        tick();
        checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL zero_done_once: got %b want 0", done_tick); end
    endtask

    // Space: 28 low cycles from LOAD, done_tick, no err_tick
    task automatic test_space();
        int n, ones, errs;
        accept(8'h20, 1'b0);
        tick(); tick();
        count_to_done(n, ones, errs);
        checks++; if (n != 28) begin errors++; $display("FAIL space_len: got %0d want 28", n); end
        checks++; if (ones != 0 || errs != 0 || err_tick !== 1'b0) begin
            errors++; $display("FAIL space_quiet: got highs=%0d errs=%0d err=%b want 0/0/0", ones, errs, err_tick);
        end
        tick();
    endtask

    // Unsupported char: err_tick at LOAD, no key, back to ready with it
    task automatic test_error(input logic [7:0] ch);
        accept(ch, 1'b0);
        tick();
        checks++; if (err_tick !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL err_lookup ch=%h: got err=%b ready=%b want 0/0", ch, err_tick, in_ready);
        end
        tick();
        checks++; if (err_tick !== 1'b1 || done_tick !== 1'b0 || morse_out !== 1'b0) begin
            errors++; $display("FAIL err_pulse ch=%h: got err=%b done=%b morse=%b want 1/0/0", ch, err_tick, done_tick, morse_out);
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL err_ready ch=%h: got %b want 1", ch, in_ready); end
        tick();
        checks++; if (err_tick !== 1'b0 || morse_out !== 1'b0) begin
            errors++; $display("FAIL err_width ch=%h: got err=%b morse=%b want 0/0", ch, err_tick, morse_out);
        end
    endtask

    // Reset in the middle of T's dash, then a fresh 'E'
    task automatic test_reset_mid();
        accept(8'h54, 1'b0);
        tick(); tick();
        repeat (5) tick();
        checks++; if (morse_out !== 1'b1) begin errors++; $display("FAIL mid_dash_high: got %b want 1", morse_out); end
        reset_n = 1'b0;
        tick();
        checks++; if (morse_out !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset: got morse=%b busy=%b ready=%b want 0/0/1", morse_out, busy, in_ready);
        end
        checks++; if (done_tick !== 1'b0 || err_tick !== 1'b0) begin
            errors++; $display("FAIL mid_reset_ticks: got done=%b err=%b want 0/0", done_tick, err_tick);
        end
        tick();
        reset_n = 1'b1;
        tick();
        test_dot(8'h45);
    endtask

    initial begin
        test_reset();
        test_dot(8'h45);
        test_back_to_back();
        test_zero();
        test_space();
        test_error(8'h7F);
        test_error(8'h23);
        test_dot(8'h65);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
